// File: rtl/seq_divider_4_bits_if.sv
// Start/done handshake bundle for the sequential restoring divider.
// The master drives the request and operands; the slave returns status and results.
interface seq_divider_4_bits_if #(
  parameter int N = 4
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_4_bits.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Error cases (zero divisor, quotient overflow) take a one-cycle ERR detour instead of iterating.
//
// state | meaning
// IDLE  | waiting for start; results and flags hold
// RUN   | iterating, one quotient bit resolved per edge
// ERR   | one cycle before reporting div-by-zero or overflow
module seq_divider_4_bits #(
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  seq_divider_4_bits_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  r_reg, q_reg, dvs_reg;
  logic [CW-1:0] cnt;
  logic          err_dz;
  logic          done_reg, dz_reg, ov_reg;
  logic [N-1:0]  quot_reg, rem_reg;

  logic          dz_in, ov_in;
  logic [N:0]    t, diff;
  logic          ge;
  logic [N-1:0]  r_step, q_step;

  always_comb begin
    dz_in  = (bus.divisor == '0);
    ov_in  = (bus.dividend[2*N-1:N] >= bus.divisor);
    t      = {r_reg, q_reg[N-1]};
    ge     = (t >= {1'b0, dvs_reg});
    diff   = t - {1'b0, dvs_reg};
    // R < divisor holds before each shift, so the difference always fits in N bits
    r_step = ge ? diff[N-1:0] : t[N-1:0];
    q_step = {q_reg[N-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (dz_in || ov_in) ? ERR : RUN;
      RUN:  if (cnt == '0) state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state == RUN);
    bus.done        = done_reg;
    bus.quotient    = quot_reg;
    bus.remainder   = rem_reg;
    bus.div_by_zero = dz_reg;
    bus.overflow    = ov_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg    <= '0;
      q_reg    <= '0;
      dvs_reg  <= '0;
      cnt      <= '0;
      err_dz   <= 1'b0;
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      ov_reg   <= 1'b0;
      quot_reg <= '0;
      rem_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvs_reg <= bus.divisor;
            r_reg   <= bus.dividend[2*N-1:N];
            q_reg   <= bus.dividend[N-1:0];
            cnt     <= CW'(N - 1);
            err_dz  <= dz_in;
            dz_reg  <= 1'b0;
            ov_reg  <= 1'b0;
          end
        end
        RUN: begin
          r_reg <= r_step;
          q_reg <= q_step;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            quot_reg <= q_step;
            rem_reg  <= r_step;
            done_reg <= 1'b1;
          end
        end
        ERR: begin
          done_reg <= 1'b1;
          quot_reg <= '1;
          // zero divisor wins over overflow; it reports the low dividend half as remainder
          if (err_dz) begin
            dz_reg  <= 1'b1;
            rem_reg <= q_reg;
          end else begin
            ov_reg  <= 1'b1;
            rem_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_4_bits.sv
// Scoreboard bench for seq_divider_4_bits: expectations queued at start, checked on done.
// Also checks done timing, busy length, back-to-back, ignored start and mid-run reset.
module tb_seq_divider_4_bits;
  localparam int N = 4;

  typedef struct {
    int q;
    int r;
    int dz;
    int ov;
    int done_cyc;
    int busy_len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   accepted = 0;
  int   dones = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  seq_divider_4_bits_if #(.N(N)) bus ();

  seq_divider_4_bits #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int x, input int d, input int c);
    exp_t e;
    e.dz = 0;
    e.ov = 0;
    if (d == 0) begin
      e.dz = 1; e.q = 15; e.r = x % 16;
    end else if ((x / 16) >= d) begin
      e.ov = 1; e.q = 15; e.r = 0;
    end else begin
      e.q = x / d; e.r = x % d;
    end
    e.busy_len = (e.dz || e.ov) ? 0 : N;
    e.done_cyc = c + 1 + ((e.dz || e.ov) ? 1 : N);
    return e;
  endfunction

  // caller must be at a falling edge
  task automatic drive(input int x, input int d);
    bus.start    = 1'b1;
    bus.dividend = 8'(x);
    bus.divisor  = 4'(d);
    sb.push_back(model(x, d, cyc));
    accepted++;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        dones++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", int'(bus.quotient), e.q);
          check("remainder", int'(bus.remainder), e.r);
          check("div_by_zero", int'(bus.div_by_zero), e.dz);
          check("overflow", int'(bus.overflow), e.ov);
          check("done_cycle", cyc, e.done_cyc);
          check("busy_len", busy_cnt, e.busy_len);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    drive(143, 13); wait_done();
    @(negedge clk);
    drive(100, 7);  wait_done();
    drive(0, 5);    wait_done();
    drive(225, 15); wait_done();
    @(negedge clk);
    drive(200, 0);  wait_done();
    drive(255, 15); wait_done();
    drive(0, 0);    wait_done();
    drive(100, 7);  wait_done();
    check("flags_cleared_dz", int'(bus.div_by_zero), 0);
    check("flags_cleared_ov", int'(bus.overflow), 0);

    // back-to-back: second start issued in the done cycle of the first
    drive(143, 13); wait_done();
    drive(143, 11); wait_done();

    // start pulsed mid-run must be ignored
    @(negedge clk);
    drive(100, 7);
    bus.start = 1'b1; bus.dividend = 8'd255; bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // asynchronous reset two cycles into RUN
    @(negedge clk);
    drive(225, 15);
    @(negedge clk);
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_quotient", int'(bus.quotient), 0);
    check("arst_remainder", int'(bus.remainder), 0);
    check("arst_dz", int'(bus.div_by_zero), 0);
    check("arst_ov", int'(bus.overflow), 0);
    accepted--;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    drive(143, 13); wait_done();

    for (int i = 0; i < 40; i++) begin
      int d, x;
      d = $urandom_range(1, 15);
      x = $urandom_range(0, d * 16 - 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      drive(x, d);
      wait_done();
    end

    repeat (4) @(negedge clk);
    check("done_count", dones, accepted);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_divider_4_bits.md
Name: seq_divider_4_bits

Overview:
Sequential restoring divider, the inverse of the 4-bit array multiplier: divides a 2N-bit dividend (product width) by an N-bit divisor to give an N-bit quotient and N-bit remainder. It resolves one quotient bit per clock and uses a start/done handshake. It sits beside the multiplier in the arithmetic library, so that A*B = P can be recovered as P / B = A.

Parameters:
N, 4, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits (N >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when idle
dividend  input  2N  numerator, captured on accepted start
divisor  input  N  denominator, captured on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse, results valid
quotient  output  N  result, held until next accepted start
remainder  output  N  result, held until next accepted start
div_by_zero  output  1  error flag, valid with done, held
overflow  output  1  quotient does not fit in N bits, valid with done, held

Behaviour:
- Reset is asynchronous (clock not required): state IDLE; busy, done, quotient, remainder, div_by_zero, overflow, iteration counter and internal registers all 0.
- States:
  - IDLE: busy=0. start=1 at edge k is accepted. Operands are latched and both flags are cleared.
    - divisor==0 -> state ERR.
    - dividend[2N-1:N] >= divisor -> state ERR with overflow.
    - otherwise -> state RUN, busy=1, counter=N-1, partial remainder R = dividend[2N-1:N], shift register Q = dividend[N-1:0].
  - RUN: on each edge:
    - T = {R, Q[N-1]} (N+1 bits).
    - If T >= divisor: R <= T - divisor and shift 1 into Q LSB; else R <= T[N-1:0] and shift 0 into Q LSB.
    - Q shifts left.
    - Counter decrements. On the edge where counter==0: quotient <= final Q, remainder <= final R, done <= 1, busy <= 0, state IDLE.
  - ERR: one cycle; on the next edge done <= 1, state IDLE.
    - Divide-by-zero: div_by_zero=1, quotient={N{1}}, remainder=dividend[N-1:0].
    - Overflow: overflow=1, quotient={N{1}}, remainder=0.
- Latency:
  - Valid division: start accepted at edge k -> done high in the cycle after edge k+N. busy is high after edges k..k+N-1.
  - Error: done high in the cycle after edge k+1. busy stays 0 for error cases.
- done is a single-cycle pulse. Outputs hold between operations.
- During the done cycle the FSM is IDLE, so a start in that cycle is accepted (back-to-back throughput of N+1 cycles). The new start clears div_by_zero and overflow.
- start while busy or in ERR: ignored. Operand inputs are don't-care except on an accepted start.
- div_by_zero takes priority over overflow when both conditions hold.
- Invariant: R < divisor before each shift, so T - divisor fits in N bits. remainder < divisor always for valid results.
- Reset asserted mid-operation aborts immediately to the reset state. No done is produced for the aborted operation.
- Arithmetic is unsigned only.

Test Plan:
- Basic division: N=4, dividend=143, divisor=13, start at edge k -> done after edge k+4; quotient=11, remainder=0; flags 0; busy high exactly 4 cycles.
- Non-zero remainder and minimum dividend:
  - 100/7 -> quotient=14, remainder=2.
  - 0/5 -> quotient=0, remainder=0.
  - 225/15 -> quotient=15, remainder=0 (largest fitting quotient).
- Divide-by-zero and overflow error paths:
  - 200/0 -> done after edge k+1; div_by_zero=1, overflow=0, quotient=15, remainder=8, busy never high.
  - 255/15 -> overflow=1, quotient=15, remainder=0.
- Back-to-back and ignored start:
  - Start asserted in the done cycle with 143/11 -> second done after 4 more edges; quotient=13, remainder=0; flags cleared.
  - Start pulsed mid-RUN with other operands -> ignored; first result unchanged.
- Reset mid-operation: assert rst asynchronously (between clock edges) two cycles into RUN -> all outputs 0 immediately, no done. After release, 143/13 completes normally.
- Randomised sweep against a reference model: all dividend < divisor*16 with divisor 1..15 -> quotient*divisor + remainder == dividend and remainder < divisor; done exactly once per accepted start.
